// File: rtl/booth_radix4_seq_multiplier.sv
// booth_radix4_seq_multiplier: iterative radix-4 Booth multiplier retiring one digit per clock
module booth_radix4_seq_multiplier #(
    parameter int WIDTH = 24,
    parameter int EARLY_TERM = 0,
    localparam int E = (WIDTH % 2 == 0) ? WIDTH + 2 : WIDTH + 1,
    localparam int D = E / 2,
    localparam int CW = $clog2(D + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy,
    output logic [CW-1:0]        digits_used
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_n;
    logic [E:0] m, m_n;
    logic [2*E-1:0] bs, acc, acc_n, addend;
    logic [CW-1:0] cnt, cnt_n;
    logic [E-1:0] a_ext, b_ext;
    logic accept, finish;
    assign a_ext = {{(E-WIDTH){signed_mode & a[WIDTH-1]}}, a};
    assign b_ext = {{(E-WIDTH){signed_mode & b[WIDTH-1]}}, b};
    assign accept = state == IDLE && in_valid;
    // Booth digit decode and the post-step register values
    always_comb begin
        addend = (m[2:0] == 3'b001 || m[2:0] == 3'b010) ? bs :
                 (m[2:0] == 3'b011) ? bs << 1 :
                 (m[2:0] == 3'b100) ? -(bs << 1) :
                 (m[2:0] == 3'b101 || m[2:0] == 3'b110) ? -bs : '0;
        acc_n = acc + addend;
        m_n = {{2{m[E]}}, m[E:2]};
        cnt_n = cnt + CW'(1);
        finish = cnt_n == CW'(D) || (EARLY_TERM != 0 && (m_n == '0 || &m_n));
    end
    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= state_n;
    end
    // next state and handshake outputs; an unknown encoding falls back to IDLE
    always_comb begin
        in_ready = state == IDLE;
        out_valid = state == DONE;
        busy = state == RUN || state == DONE;
        state_n = accept ? RUN :
                  (state == RUN && finish) ? DONE :
                  (state == DONE && out_ready) ? IDLE :
                  (state == IDLE || state == RUN || state == DONE) ? state : IDLE;
    end
    // operand load, digit step and result capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m <= '0;
            bs <= '0;
            acc <= '0;
            cnt <= '0;
            product <= '0;
            digits_used <= '0;
        end else if (accept) begin
            m <= {a_ext, 1'b0};
            bs <= {{E{b_ext[E-1]}}, b_ext};
            acc <= '0;
            cnt <= '0;
        end else if (state == RUN) begin
            m <= m_n;
            bs <= bs << 2;
            acc <= acc_n;
            cnt <= cnt_n;
            if (finish) begin
                product <= acc_n[2*WIDTH-1:0];
                digits_used <= cnt_n;
            end
        end
    end
endmodule

// File: doc/booth_radix4_seq_multiplier.md
# booth_radix4_seq_multiplier

Iterative radix-4 modified-Booth multiplier that retires one Booth digit per clock into a shifted partial-product accumulator. It produces a full 2*WIDTH-bit product for unsigned or two's-complement operands selected per transaction. Optional early termination stops the multiply as soon as all remaining digits are zero. It sits beside the combinational Booth recoding stage in the FMA datapath as the area-optimised significand multiplier option, with valid/ready handshakes on both sides.

## Interface
- WIDTH, 24, operand width in bits; must be ≥ 4
- EARLY_TERM, 0, 1 = finish once every remaining Booth digit is zero; 0 = always run all digits
- Derived, not overridable: E = WIDTH+2 if WIDTH even, else WIDTH+1 (extended width, always even); D = E/2 (digit count); CW = $clog2(D+1)

- clk  input  1  rising-edge clock
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  operands present
- in_ready  output  1  block can accept; high only in IDLE
- signed_mode  input  1  1 = a and b are two's complement; 0 = unsigned; sampled on accept
- a  input  WIDTH  multiplier; this operand is Booth-recoded
- b  input  WIDTH  multiplicand
- out_valid  output  1  product valid; high only in DONE
- out_ready  input  1  consumer takes the product
- product  output  2*WIDTH  result; held stable while out_valid is high
- busy  output  1  high in RUN or DONE
- digits_used  output  CW  number of Booth digits processed for the current or last product

## Operation
- Extension on accept: a and b are each extended to E bits, sign-extended if signed_mode = 1 and zero-extended otherwise. This gives A_ext and B_ext.
- Registers:
  - M: E+1 bits, loaded with {A_ext, 1'b0}.
  - Bs: 2E bits, loaded with B_ext sign-extended to 2E bits.
  - ACC: 2E bits, cleared to 0.
  - cnt: cleared to 0.
- Digit step, one per RUN cycle. The triplet {M[2],M[1],M[0]} selects the addend:
  - 000 → 0
  - 001 or 010 → +Bs
  - 011 → +2Bs
  - 100 → −2Bs
  - 101 or 110 → −Bs
  - 111 → 0
- Each digit step performs, all modulo 2^(2E):
  - ACC ← ACC + addend
  - Bs ← Bs << 2
  - M ← M arithmetic-shifted right by 2, replicating the top bit
  - cnt ← cnt + 1
- States and transitions:
  - IDLE: in_ready = 1. On in_valid, load the registers and go to RUN.
  - RUN: perform one digit step per cycle. Go to DONE when the post-step cnt = D, or when EARLY_TERM = 1 and the post-step M has all bits equal.
  - DONE: out_valid = 1. Go to IDLE when out_ready = 1.
- On entry to DONE: product ← ACC[2*WIDTH-1:0] and digits_used ← post-step cnt. The low 2*WIDTH bits are exact in both modes.
- Every RUN performs at least one digit step, including when a = 0.
- In DONE, in_valid is ignored. No operand is accepted until the next IDLE cycle, so there is no same-cycle DONE→accept.
- Reset mid-operation: the transaction is discarded and no partial product is ever presented.

## Timing
- Reset values:
  - state = IDLE, so in_ready = 1
  - out_valid = 0, busy = 0
  - product = 0, digits_used = 0
  - M, Bs, ACC and cnt = 0
- Accept happens on the edge where in_valid & in_ready = 1; call it edge T.
- Latency:
  - out_valid rises after edge T+k, where k = digits processed.
  - k = D when EARLY_TERM = 0; 1 ≤ k ≤ D when EARLY_TERM = 1.
  - WIDTH=24: E=26, D=13, so worst-case accept-to-valid is 13 edges.
- Handshake completion:
  - The output transfer completes on the edge with out_valid & out_ready = 1.
  - in_ready rises on the next cycle.
  - Minimum period between accepts is k+2 cycles.
- Backpressure: while out_ready = 0, product, out_valid and digits_used hold unchanged indefinitely.
- The multiply result depends only on values sampled at accept; later changes on a, b or signed_mode have no effect.

## Test plan
- WIDTH=8, EARLY_TERM=0, unsigned, a=255, b=255 → product=16'hFE01 (65025), digits_used=5, out_valid 5 edges after accept.
- WIDTH=8, signed, a=−128 (8'h80), b=127 (8'h7F) → product=16'hC080 (−16256). Also signed a=8'hFF, b=8'hFF → 16'h0001.
- WIDTH=8, EARLY_TERM=1, unsigned:
  - a=1, b=100 → product=100, digits_used=1.
  - a=3, b=100 → product=300, digits_used=2.
  - a=0 → product=0, digits_used=1.
- Backpressure: hold out_ready=0 for 4 cycles after out_valid rises, driving in_valid=1 with new operands throughout. Required: product stable, in_ready=0, no new accept. The new operands are accepted only in the cycle after the out_valid&out_ready edge.
- Reset mid-RUN:
  - Assert rst at digit 3 of an unsigned 8'hAB×8'hCD multiply. Required: out_valid=0, product=0 and in_ready=1 immediately, with no stale output.
  - A subsequent 8'hAB×8'hCD multiply then gives 16'h88EF.
- Random sweep, WIDTH ∈ {8, 9, 24}, EARLY_TERM ∈ {0, 1}, ≥10k transactions with random valid/ready gaps. Every product must match the reference a*b in the selected mode, and every digits_used must be ≤ D.
